// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage and its channel FIFOs.
package wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Register $0 is hardwired to zero; writes to it are dropped at the port.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_rr_stage_if.sv
// Producer-side request bus and register-file write port of the writeback stage.
interface wb_rr_stage_if
    import wb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                       flush;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH-1:0]          in_ready;
    logic [NUM_CH*ADDR_W-1:0]   in_addr;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic                       we;
    logic [ADDR_W-1:0]          wAddr;
    logic [DATA_W-1:0]          wData;
    logic                       busy;

    modport master (
        output flush, in_valid, in_addr, in_data,
        input  in_ready, we, wAddr, wData, busy
    );

    modport slave (
        input  flush, in_valid, in_addr, in_data,
        output in_ready, we, wAddr, wData, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// Per-channel circular buffer holding {addr, data} write requests.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic                     do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // A push into a full buffer is ignored even if it pops on the same edge.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign {head_addr_o, head_data_o} = mem_q[rd_q];

    // Next pointers/count; flush wins over push and pop. DEPTH is a power
    // of two so pointers wrap by plain overflow.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= {addr_i, data_i};
    end
endmodule

// File: rtl/wb_rr_stage.sv
// Multi-channel writeback stage: per-channel FIFOs, round-robin grant,
// registered single register-file write port.
module wb_rr_stage
    import wb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_rr_stage_if.slave  bus
);
    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]             full, empty;
    logic [NUM_CH-1:0][ADDR_W-1:0] head_addr;
    logic [NUM_CH-1:0][DATA_W-1:0] head_data;

    logic [RR_W-1:0]   rr_q, rr_d;
    logic              grant_vld;
    logic [RR_W-1:0]   grant_idx;
    int                idx;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wb_fifo #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (bus.flush),
            .push_i      (bus.in_valid[i]),
            .pop_i       (grant_vld && (grant_idx == RR_W'(i))),
            .addr_i      (bus.in_addr[i*ADDR_W +: ADDR_W]),
            .data_i      (bus.in_data[i*DATA_W +: DATA_W]),
            .full_o      (full[i]),
            .empty_o     (empty[i]),
            .head_addr_o (head_addr[i]),
            .head_data_o (head_data[i])
        );
    end

    // Ready is forced low while reset is asserted, independent of the clock.
    assign bus.in_ready = ~full & {NUM_CH{~rst}};

    // Grant the first non-empty channel starting from the round-robin pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
    end

    // Pointer advance and output-register next state; flush drops the grant.
    always_comb begin
        rr_d    = rr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (!bus.flush && grant_vld) begin
            rr_d    = (grant_idx == RR_W'(NUM_CH - 1)) ? '0 : grant_idx + RR_W'(1);
            we_d    = (head_addr[grant_idx] != ADDR_W'(REG_ZERO));
            waddr_d = head_addr[grant_idx];
            wdata_d = head_data[grant_idx];
        end
    end

    // Arbiter pointer and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.we    = we_q;
    assign bus.wAddr = waddr_q;
    assign bus.wData = wdata_q;
    assign bus.busy  = (~&empty) | we_q;
endmodule

// File: tb/tb_wb_rr_stage.sv
// Scoreboard bench for wb_rr_stage: a behavioural queue model predicts each
// cycle's write-port value, pushed when stimulus is driven, popped after the edge.
module tb_wb_rr_stage;
    import wb_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_rr_stage_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_rr_stage #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t mq [NUM_CH][$];
    out_t exp_q [$];
    out_t mcur;
    int   mrr;
    int   checks   = 0;
    int   failures = 0;
    bit   rdy_low_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input int a, input int d);
        ent_t e;
        e.a = ADDR_W'(a);
        e.d = DATA_W'(d);
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, check ready/busy mid-cycle,
    // predict the next write-port value, then compare it after the rising edge.
    task automatic cyc(input bit fl, input logic [NUM_CH-1:0] v, input ent_t e0, input ent_t e1);
        ent_t e [NUM_CH];
        bit   rdy [NUM_CH];
        bit   busy_m;
        out_t nx, o;
        ent_t hd;
        int   g, id;
        e[0] = e0;
        e[1] = e1;
        bus.flush    = fl;
        bus.in_valid = v;
        bus.in_addr  = {e1.a, e0.a};
        bus.in_data  = {e1.d, e0.d};
        #1;
        busy_m = mcur.we;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rdy[ch] = (mq[ch].size() < DEPTH);
            if (mq[ch].size() > 0) busy_m = 1'b1;
            chk($sformatf("in_ready%0d", ch), 64'(bus.in_ready[ch]), 64'(rdy[ch]));
            if (!bus.in_ready[ch]) rdy_low_seen = 1'b1;
        end
        chk("busy", 64'(bus.busy), 64'(busy_m));
        nx    = mcur;
        nx.we = 1'b0;
        if (fl) begin
            for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
        end else begin
            g = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                id = (mrr + k) % NUM_CH;
                if (g < 0 && mq[id].size() > 0) g = id;
            end
            if (g >= 0) begin
                hd    = mq[g].pop_front();
                nx.we = (hd.a != ADDR_W'(REG_ZERO));
                nx.a  = hd.a;
                nx.d  = hd.d;
                mrr   = (g + 1) % NUM_CH;
            end
            for (int ch = 0; ch < NUM_CH; ch++)
                if (v[ch] && rdy[ch]) mq[ch].push_back(e[ch]);
        end
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
        o    = exp_q.pop_front();
        mcur = o;
        chk("we",    64'(bus.we),    64'(o.we));
        chk("wAddr", 64'(bus.wAddr), 64'(o.a));
        chk("wData", 64'(bus.wData), 64'(o.d));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
        mrr  = 0;
        mcur = '0;
    endtask

    initial begin
        bus.flush    = 1'b0;
        bus.in_valid = '0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        model_reset();
        #1;
        chk("rst_we",       64'(bus.we),       64'd0);
        chk("rst_wAddr",    64'(bus.wAddr),    64'd0);
        chk("rst_wData",    64'(bus.wData),    64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single push: write appears two edges later for exactly one cycle.
        cyc(1'b0, 2'b01, mk(3, 'h11), '0);
        idle(4);

        // Both channels push every cycle; keeps ch0 full with same-edge push/pop.
        rdy_low_seen = 1'b0;
        for (int i = 0; i < 24; i++)
            cyc(1'b0, 2'b11, mk(1 + (i % 8), 'h100 + i), mk(9 + (i % 8), 'h10100 + i));
        chk("ready_dropped", 64'(rdy_low_seen), 64'd1);
        idle(12);

        // Write to $0 consumes a slot with we low.
        cyc(1'b0, 2'b01, mk(0, 'hDEAD), '0);
        cyc(1'b0, 2'b01, mk(2, 'h22), '0);
        idle(4);

        // Fill ch0, then flush with a simultaneous push.
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 2'b11, mk(4 + i, 'h200 + i), mk(16 + i, 'h20200 + i));
        cyc(1'b1, 2'b01, mk(7, 'hBAD), '0);
        idle(4);

        // Asynchronous reset between edges with entries buffered.
        cyc(1'b0, 2'b10, '0, mk(13, 'h3131));
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 2'b11, mk(5 + i, 'h300 + i), mk(20 + i, 'h30300 + i));
        bus.in_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_we",       64'(bus.we),       64'd0);
        chk("arst_wAddr",    64'(bus.wAddr),    64'd0);
        chk("arst_wData",    64'(bus.wData),    64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("arst_busy",     64'(bus.busy),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 2'b11, mk(6, 'h6060), mk(14, 'h1414));
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
